bus_cycle_sequencer: RTL and testbench

- Generates the T-state timing and the cycle-type flags for every external bus cycle (opcode fetch, memory read/write, IO read/write).
- Sits directly upstream of pin_control. Its fFetch/fMRead/fMWrite/fIORead/fIOWrite and T1..T4 outputs drive pin_control's inputs one-to-one.
- Accepts cycle requests from the execution/decode logic and handles wait-state insertion from the nWAIT pin.

---
 rtl/cpu_bus_pkg.sv | 15 +
 rtl/bus_cycle_sequencer_wait_timer.sv | 20 ++
 rtl/bus_cycle_sequencer.sv | 81 ++++++++
 tb/tb_bus_cycle_sequencer.sv | 115 +++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: bus-cycle type and T-state encodings shared by the sequencer and pin_control
package cpu_bus_pkg;
   typedef enum logic [2:0] {
      CYC_NONE    = 3'd0,
      CYC_FETCH   = 3'd1,
      CYC_MREAD   = 3'd2,
      CYC_MWRITE  = 3'd3,
      CYC_IOREAD  = 3'd4,
      CYC_IOWRITE = 3'd5
   } cycle_t;
   typedef enum logic [2:0] {IDLE, ST1, ST2, STWA, STW, ST3, ST4} tstate_t;
   function automatic logic is_legal(cycle_t c);
      return c inside {CYC_FETCH, CYC_MREAD, CYC_MWRITE, CYC_IOREAD, CYC_IOWRITE};
   endfunction
endpackage

// File: rtl/bus_cycle_sequencer_wait_timer.sv
// wait_timer: counts consecutive STW clocks and flags the clock on which the limit is reached
module wait_timer #(
   parameter int WAIT_TIMEOUT = 0,
   parameter int TO_W         = 8
) (
   input  logic clk,
   input  logic nreset,
   input  logic clr,
   input  logic inc,
   output logic expired
);
   localparam logic [TO_W-1:0] LIM = TO_W'(WAIT_TIMEOUT == 0 ? 0 : WAIT_TIMEOUT - 1);
   logic [TO_W-1:0] cnt;
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
   // the edge that would bring the count to WAIT_TIMEOUT is the forced exit
   assign expired = WAIT_TIMEOUT != 0 && cnt == LIM;
endmodule

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: T-state timing, cycle-type flags and wait insertion for external bus cycles
module bus_cycle_sequencer
   import cpu_bus_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 0,
   parameter int TO_W         = 8
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       cycle_req,
   input  logic [2:0] cycle_type,
   input  logic       nwait,
   output logic       cycle_ack,
   output logic       cycle_done,
   output logic       busy,
   output logic       fFetch,
   output logic       fMRead,
   output logic       fMWrite,
   output logic       fIORead,
   output logic       fIOWrite,
   output logic       T1,
   output logic       T2,
   output logic       T3,
   output logic       T4,
   output logic       tw,
   output logic       wait_timeout,
   output logic       bad_req
);
   tstate_t state, nxt;
   cycle_t  ctype, ntype;
   logic    final_st, open, legal, accept, bad, expired, forced, io;
   wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .TO_W(TO_W)) u_timer (
      .clk     (clk),
      .nreset  (nreset),
      .clr     (nxt == ST3),
      .inc     (state == STW),
      .expired (expired)
   );
   always_comb begin
      final_st = state == ST4 || (state == ST3 && ctype != CYC_FETCH);
      open     = state == IDLE || final_st;
      legal    = is_legal(cycle_t'(cycle_type));
      accept   = open && cycle_req && legal;
      bad      = open && cycle_req && !legal;
      io       = ctype inside {CYC_IOREAD, CYC_IOWRITE};
      forced   = state == STW && expired && !nwait;
      ntype    = accept ? cycle_t'(cycle_type) : ctype;
      nxt      = accept            ? ST1 :
                 open              ? IDLE :
                 state == ST1      ? ST2 :
                 state == ST2      ? (io ? STWA : nwait ? ST3 : STW) :
                 state == STWA     ? (nwait ? ST3 : STW) :
                 state == STW      ? (nwait || expired ? ST3 : STW) :
                                     ST4;
   end
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         state <= IDLE;
         ctype <= CYC_NONE;
         {cycle_ack, cycle_done, busy, fFetch, fMRead, fMWrite, fIORead, fIOWrite} <= '0;
         {T1, T2, T3, T4, tw, wait_timeout, bad_req} <= '0;
      end else begin
         state        <= nxt;
         ctype        <= ntype;
         cycle_ack    <= accept;
         cycle_done   <= nxt == ST4 || (nxt == ST3 && ntype != CYC_FETCH);
         busy         <= nxt != IDLE;
         fFetch       <= nxt != IDLE && ntype == CYC_FETCH;
         fMRead       <= nxt != IDLE && ntype == CYC_MREAD;
         fMWrite      <= nxt != IDLE && ntype == CYC_MWRITE;
         fIORead      <= nxt != IDLE && ntype == CYC_IOREAD;
         fIOWrite     <= nxt != IDLE && ntype == CYC_IOWRITE;
         T1           <= nxt == ST1;
         T2           <= nxt inside {ST2, STWA, STW};
         T3           <= nxt == ST3;
         T4           <= nxt == ST4;
         tw           <= nxt inside {STWA, STW};
         wait_timeout <= wait_timeout | forced;
         bad_req      <= bad;
      end
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// tb_bus_cycle_sequencer: table-driven cycle vectors plus async-reset sequence for bus_cycle_sequencer
module tb_bus_cycle_sequencer;
   localparam logic [14:0] ACK = 15'h4000, DONE = 15'h2000, BUSY = 15'h1000;
   localparam logic [14:0] FF = 15'h0800, FMR = 15'h0400, FMW = 15'h0200, FIR = 15'h0100, FIW = 15'h0080;
   localparam logic [14:0] K_T1 = 15'h0040, K_T2 = 15'h0020, K_T3 = 15'h0010, K_T4 = 15'h0008;
   localparam logic [14:0] TW = 15'h0004, WTO = 15'h0002, BAD = 15'h0001;
   typedef struct {
      logic        req;
      logic [2:0]  typ;
      logic        nw;
      logic [14:0] exp;
   } vec_t;
   logic clk = 1'b0, nreset = 1'b0, cycle_req = 1'b0, nwait = 1'b1;
   logic [2:0] cycle_type = 3'd0;
   logic cycle_ack, cycle_done, busy, f_fetch, f_mread, f_mwrite, f_ioread, f_iowrite;
   logic t1, t2, t3, t4, tw, wait_timeout, bad_req;
   logic [14:0] outs;
   int checks = 0, failures = 0;
   vec_t v[$];
   always #5 clk = ~clk;
   bus_cycle_sequencer #(.WAIT_TIMEOUT(3), .TO_W(8)) dut (
      .clk(clk), .nreset(nreset), .cycle_req(cycle_req), .cycle_type(cycle_type), .nwait(nwait),
      .cycle_ack(cycle_ack), .cycle_done(cycle_done), .busy(busy),
      .fFetch(f_fetch), .fMRead(f_mread), .fMWrite(f_mwrite), .fIORead(f_ioread), .fIOWrite(f_iowrite),
      .T1(t1), .T2(t2), .T3(t3), .T4(t4), .tw(tw), .wait_timeout(wait_timeout), .bad_req(bad_req)
   );
   assign outs = {cycle_ack, cycle_done, busy, f_fetch, f_mread, f_mwrite, f_ioread, f_iowrite,
                  t1, t2, t3, t4, tw, wait_timeout, bad_req};
   task automatic check(input string name, input logic [14:0] exp);
      checks++;
      if (outs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, outs, exp);
      end
   endtask
   task automatic step(input logic req, input logic [2:0] typ, input logic nw);
      @(negedge clk);
      cycle_req = req;
      cycle_type = typ;
      nwait = nw;
      @(posedge clk);
      #1;
   endtask
   initial begin
      // FETCH, no waits
      v.push_back('{1'b1, 3'd1, 1'b1, ACK | BUSY | FF | K_T1});
      v.push_back('{1'b0, 3'd1, 1'b1, BUSY | FF | K_T2});
      v.push_back('{1'b0, 3'd0, 1'b1, BUSY | FF | K_T3});
      v.push_back('{1'b0, 3'd0, 1'b1, DONE | BUSY | FF | K_T4});
      v.push_back('{1'b0, 3'd0, 1'b1, 15'h0});
      // MWRITE with two pin waits
      v.push_back('{1'b1, 3'd3, 1'b0, ACK | BUSY | FMW | K_T1});
      v.push_back('{1'b0, 3'd3, 1'b0, BUSY | FMW | K_T2});
      v.push_back('{1'b0, 3'd3, 1'b0, BUSY | FMW | K_T2 | TW});
      v.push_back('{1'b0, 3'd3, 1'b0, BUSY | FMW | K_T2 | TW});
      v.push_back('{1'b0, 3'd3, 1'b1, DONE | BUSY | FMW | K_T3});
      v.push_back('{1'b0, 3'd3, 1'b1, 15'h0});
      // IOREAD with the automatic wait, then back-to-back MREAD
      v.push_back('{1'b1, 3'd4, 1'b1, ACK | BUSY | FIR | K_T1});
      v.push_back('{1'b0, 3'd4, 1'b1, BUSY | FIR | K_T2});
      v.push_back('{1'b0, 3'd4, 1'b1, BUSY | FIR | K_T2 | TW});
      v.push_back('{1'b1, 3'd2, 1'b1, DONE | BUSY | FIR | K_T3});
      v.push_back('{1'b1, 3'd2, 1'b1, ACK | BUSY | FMR | K_T1});
      v.push_back('{1'b0, 3'd7, 1'b1, BUSY | FMR | K_T2});
      v.push_back('{1'b0, 3'd7, 1'b1, DONE | BUSY | FMR | K_T3});
      // illegal types: in a final state and while idle
      v.push_back('{1'b1, 3'd0, 1'b1, BAD});
      v.push_back('{1'b1, 3'd7, 1'b1, BAD});
      v.push_back('{1'b0, 3'd7, 1'b1, 15'h0});
      v.push_back('{1'b1, 3'd6, 1'b1, BAD});
      v.push_back('{1'b0, 3'd6, 1'b1, 15'h0});
      // MREAD with nwait stuck low: three STW clocks, then forced T3
      v.push_back('{1'b1, 3'd2, 1'b0, ACK | BUSY | FMR | K_T1});
      v.push_back('{1'b0, 3'd2, 1'b0, BUSY | FMR | K_T2});
      v.push_back('{1'b0, 3'd2, 1'b0, BUSY | FMR | K_T2 | TW});
      v.push_back('{1'b0, 3'd2, 1'b0, BUSY | FMR | K_T2 | TW});
      v.push_back('{1'b0, 3'd2, 1'b0, BUSY | FMR | K_T2 | TW});
      v.push_back('{1'b0, 3'd2, 1'b0, DONE | BUSY | FMR | K_T3 | WTO});
      v.push_back('{1'b0, 3'd2, 1'b1, WTO});
      // FETCH after timeout completes normally with the sticky flag kept
      v.push_back('{1'b1, 3'd1, 1'b1, ACK | BUSY | FF | K_T1 | WTO});
      v.push_back('{1'b0, 3'd1, 1'b1, BUSY | FF | K_T2 | WTO});
      v.push_back('{1'b0, 3'd1, 1'b1, BUSY | FF | K_T3 | WTO});
      v.push_back('{1'b0, 3'd1, 1'b1, DONE | BUSY | FF | K_T4 | WTO});
      v.push_back('{1'b0, 3'd1, 1'b1, WTO});
      #1;
      check("reset_init", 15'h0);
      step(1'b0, 3'd0, 1'b1);
      check("reset_held", 15'h0);
      @(negedge clk);
      nreset = 1'b1;
      for (int i = 0; i < v.size(); i++) begin
         step(v[i].req, v[i].typ, v[i].nw);
         check($sformatf("vec%0d", i), v[i].exp);
      end
      // asynchronous reset in the middle of an MREAD wait
      step(1'b1, 3'd2, 1'b0);
      check("mr_t1", ACK | BUSY | FMR | K_T1 | WTO);
      step(1'b0, 3'd2, 1'b0);
      step(1'b0, 3'd2, 1'b0);
      check("mr_stw", BUSY | FMR | K_T2 | TW | WTO);
      #2;
      nreset = 1'b0;
      #1;
      check("async_reset", 15'h0);
      @(negedge clk);
      nreset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'd2, 1'b1);
         check($sformatf("post_reset%0d", i), 15'h0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
